adder_tree_pipe: RTL and testbench

Parametrised pipelined signed adder tree that sums NUM_INPUTS operands per vector, e.g. to combine per-channel conv partial sums in the LeNet-5 datapath. It replaces fixed-arity adder stages. Over a fixed 6-input adder it adds arbitrary input count, automatic tree depth, a valid pipeline, stall-hold on en, output saturation and a saturation flag. It sits between the per-channel MAC/conv units and the activation/pooling stage.

---
 rtl/lenet_pkg.sv | 49 ++++
 rtl/adder_tree_level.sv | 51 +++++
 rtl/adder_tree_pipe.sv | 109 ++++++++++
 tb/tb_adder_tree_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 datapath blocks: default operand width,
// small constant-math helpers and the signed saturation used by the adder
// tree, pooling and activation stages.
package lenet_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Saturation result: clipped value (sign-extended to 64 bits) and clip bit.
    typedef struct packed {
        logic signed [63:0] value;
        logic               clip;
    } sat_result_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Ceiling integer division for element counts per tree level.
    function automatic int ceilDiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Clip a wide signed sum into an outWidth-bit signed range.
    function automatic sat_result_t saturate(input logic signed [63:0] sum,
                                             input int outWidth);
        sat_result_t        res;
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        maxVal    = (64'sd1 <<< (outWidth - 1)) - 64'sd1;
        minVal    = -(64'sd1 <<< (outWidth - 1));
        res.value = sum;
        res.clip  = 1'b0;
        if (sum > maxVal) begin
            res.value = maxVal;
            res.clip  = 1'b1;
        end else if (sum < minVal) begin
            res.value = minVal;
            res.clip  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the signed adder tree: adjacent operand pairs are
// added at one bit of growth, an odd leftover is sign-extended and carried
// through, and a valid bit travels with the data. en=0 holds everything.
module adder_tree_level
    import lenet_pkg::*;
#(
    parameter  int IN_COUNT  = 6,
    parameter  int IN_WIDTH  = 16,
    localparam int OUT_COUNT = ceilDiv(IN_COUNT, 2),
    localparam int OUT_WIDTH = IN_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           valid_i,
    input  logic [IN_COUNT*IN_WIDTH-1:0]   data_i,
    output logic [OUT_COUNT*OUT_WIDTH-1:0] data_o,
    output logic                           valid_o
);

    wire  [OUT_COUNT*OUT_WIDTH-1:0] sum_d;
    logic [OUT_COUNT*OUT_WIDTH-1:0] sum_q;
    logic                           valid_q;

    for (genvar j = 0; j < OUT_COUNT; j++) begin : gElem
        logic signed [IN_WIDTH-1:0] opA;
        assign opA = data_i[(2*j)*IN_WIDTH +: IN_WIDTH];
        if (2*j + 1 < IN_COUNT) begin : gAdd
            logic signed [IN_WIDTH-1:0] opB;
            assign opB = data_i[(2*j+1)*IN_WIDTH +: IN_WIDTH];
            assign sum_d[j*OUT_WIDTH +: OUT_WIDTH] = {opA[IN_WIDTH-1], opA} + {opB[IN_WIDTH-1], opB};
        end else begin : gPass
            assign sum_d[j*OUT_WIDTH +: OUT_WIDTH] = {opA[IN_WIDTH-1], opA};
        end
    end

    // Capture this level's sums and valid on advancing cycles; reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum_d;
            valid_q <= valid_i;
        end
    end

    assign data_o  = sum_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree summing NUM_INPUTS operands per vector, with a
// final saturating output register and a clip flag.
// Optional macro ADDER_TREE_RELU_EN: the output stage also applies ReLU after
// saturation and sat_flag then reports positive clipping only.
module adder_tree_pipe
    import lenet_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_INPUTS = 6,
    localparam int LEVELS     = clog2(NUM_INPUTS),
    localparam int SUM_WIDTH  = DATA_WIDTH + LEVELS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   datain,
    output logic signed [DATA_WIDTH-1:0]       dataout,
    output logic                               out_valid,
    output logic                               sat_flag
);

    if (NUM_INPUTS < 2 || NUM_INPUTS > 64) begin : gBadInputs
        $error("adder_tree_pipe: NUM_INPUTS must lie in 2..64");
    end
    if (SUM_WIDTH > 64) begin : gBadWidth
        $error("adder_tree_pipe: DATA_WIDTH + LEVELS must not exceed 64");
    end

    // Level k consumes ceil(N/2^(k-1)) operands of DATA_WIDTH+k-1 bits.
    for (genvar k = 1; k <= LEVELS; k++) begin : gLevel
        localparam int IN_COUNT  = ceilDiv(NUM_INPUTS, 1 << (k - 1));
        localparam int IN_WIDTH  = DATA_WIDTH + k - 1;
        localparam int OUT_COUNT = ceilDiv(IN_COUNT, 2);

        logic [IN_COUNT*IN_WIDTH-1:0]       levelIn;
        logic                               levelValidIn;
        logic [OUT_COUNT*(IN_WIDTH+1)-1:0]  levelData;
        logic                               levelValid;

        if (k == 1) begin : gFeed
            assign levelIn      = datain;
            assign levelValidIn = in_valid;
        end else begin : gFeed
            assign levelIn      = gLevel[k-1].levelData;
            assign levelValidIn = gLevel[k-1].levelValid;
        end

        adder_tree_level #(
            .IN_COUNT (IN_COUNT),
            .IN_WIDTH (IN_WIDTH)
        ) uLevel (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (levelValidIn),
            .data_i  (levelIn),
            .data_o  (levelData),
            .valid_o (levelValid)
        );
    end

    logic signed [SUM_WIDTH-1:0]  treeSum;
    logic                         treeValid;
    logic signed [DATA_WIDTH-1:0] dataOut_d;
    logic                         satFlag_d;
    logic signed [DATA_WIDTH-1:0] dataOut_q;
    logic                         outValid_q;
    logic                         satFlag_q;

    assign treeSum   = gLevel[LEVELS].levelData;
    assign treeValid = gLevel[LEVELS].levelValid;

    // Narrow the full-precision sum to the output width; returns {clip, value}.
    function automatic logic [DATA_WIDTH:0] clipToOutput(input logic signed [SUM_WIDTH-1:0] sum);
        sat_result_t r;
        r = saturate(64'(sum), DATA_WIDTH);
        return {r.clip, r.value[DATA_WIDTH-1:0]};
    endfunction

    // Saturate the tree result, optionally forcing negatives to zero.
    always_comb begin
        {satFlag_d, dataOut_d} = clipToOutput(treeSum);
`ifdef ADDER_TREE_RELU_EN
        if (dataOut_d[DATA_WIDTH-1]) begin
            dataOut_d = '0;
            satFlag_d = 1'b0;
        end
`endif
    end

    // Output register: loads every advancing cycle, holds through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
            satFlag_q  <= 1'b0;
        end else if (en) begin
            dataOut_q  <= dataOut_d;
            outValid_q <= treeValid;
            satFlag_q  <= satFlag_d;
        end
    end

    assign dataout   = dataOut_q;
    assign out_valid = outValid_q;
    assign sat_flag  = satFlag_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: a 6x16 instance for the main tests
// and a 5x8 instance for the odd-passthrough case. Honours ADDER_TREE_RELU_EN.
module tb_adder_tree_pipe;

    localparam int W   = 16;
    localparam int N   = 6;
    localparam int LAT = 4;
    localparam int W5  = 8;
    localparam int N5  = 5;
`ifdef ADDER_TREE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 inValid;
    logic [N*W-1:0]       dataIn;
    logic signed [W-1:0]  dataOut;
    logic                 outValid;
    logic                 satFlag;
    logic                 inValid5;
    logic [N5*W5-1:0]     dataIn5;
    logic signed [W5-1:0] dataOut5;
    logic                 outValid5;
    logic                 satFlag5;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.DATA_WIDTH(W), .NUM_INPUTS(N)) uDut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (inValid),
        .datain    (dataIn),
        .dataout   (dataOut),
        .out_valid (outValid),
        .sat_flag  (satFlag)
    );

    adder_tree_pipe #(.DATA_WIDTH(W5), .NUM_INPUTS(N5)) uDut5 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (inValid5),
        .datain    (dataIn5),
        .dataout   (dataOut5),
        .out_valid (outValid5),
        .sat_flag  (satFlag5)
    );

    typedef struct {
        string          name;
        logic [N*W-1:0] data;
        longint         expVal;
        logic           expSat;
    } vector_t;

    typedef struct {
        longint val;
        logic   sat;
        int     due;
    } pending_t;

    vector_t  vectors[7];
    pending_t pending[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N*W-1:0] d);
        inValid = v;
        dataIn  = d;
    endtask

    function automatic logic [N*W-1:0] pack6(input int o0, input int o1, input int o2,
                                            input int o3, input int o4, input int o5);
        return {16'(o5), 16'(o4), 16'(o3), 16'(o2), 16'(o1), 16'(o0)};
    endfunction

    function automatic logic [N*W-1:0] packAll6(input int v);
        return pack6(v, v, v, v, v, v);
    endfunction

    function automatic logic [N5*W5-1:0] pack5(input int o0, input int o1, input int o2,
                                              input int o3, input int o4);
        return {8'(o4), 8'(o3), 8'(o2), 8'(o1), 8'(o0)};
    endfunction

    // Reference: exact integer sum, then clip to w bits, then optional ReLU.
    function automatic longint sumOperands(input logic [N*W-1:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'($signed(d[i*W +: W]));
        return s;
    endfunction

    task automatic refModel(input longint sum, input int w, output longint val, output logic sat);
        longint maxV;
        longint minV;
        maxV = (longint'(1) <<< (w - 1)) - 1;
        minV = -(longint'(1) <<< (w - 1));
        val  = sum;
        sat  = 1'b0;
        if (sum > maxV) begin
            val = maxV;
            sat = 1'b1;
        end else if (sum < minV) begin
            val = minV;
            sat = 1'b1;
        end
        if (RELU && val < 0) begin
            val = 0;
            sat = 1'b0;
        end
    endtask

    function automatic int randOperand();
        case ($urandom_range(0, 3))
            0:       return 32767;
            1:       return -32768;
            2:       return int'($urandom_range(0, 200)) - 100;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Single vector through the 6-input tree: latency, value, flag, one-cycle pulse.
    task automatic runVector(input string name, input logic [N*W-1:0] d,
                             input longint expVal, input logic expSat);
        int edges;
        applyStimulus(1'b1, d);
        tick();
        applyStimulus(1'b0, '0);
        edges = 1;
        while (outValid !== 1'b1 && edges < 12) begin
            tick();
            edges++;
        end
        checkOutput({name, " latency"}, edges, LAT);
        checkOutput({name, " value"}, dataOut, expVal);
        checkOutput({name, " sat"}, satFlag, expSat);
        tick();
        checkOutput({name, " pulse"}, outValid, 0);
    endtask

    task automatic runVector5(input string name, input logic [N5*W5-1:0] d,
                              input longint expVal, input logic expSat);
        int edges;
        inValid5 = 1'b1;
        dataIn5  = d;
        tick();
        inValid5 = 1'b0;
        dataIn5  = '0;
        edges    = 1;
        while (outValid5 !== 1'b1 && edges < 12) begin
            tick();
            edges++;
        end
        checkOutput({name, " latency"}, edges, LAT);
        checkOutput({name, " value"}, dataOut5, expVal);
        checkOutput({name, " sat"}, satFlag5, expSat);
        tick();
        checkOutput({name, " pulse"}, outValid5, 0);
    endtask

    initial begin
        int       advCount;
        logic     prevValid;
        logic     prevSat;
        logic signed [W-1:0] prevData;
        logic     expValid;
        longint   mVal;
        logic     mSat;

        vectors[0] = '{"ones-to-six",   pack6(1, 2, 3, 4, 5, 6),               21,                  1'b0};
        vectors[1] = '{"all-max",       packAll6(32767),                        32767,               1'b1};
        vectors[2] = '{"all-min",       packAll6(-32768),                       RELU ? 0 : -32768,   RELU ? 1'b0 : 1'b1};
        vectors[3] = '{"mixed-edge",    pack6(32767, 1, -1, 0, 0, 0),           32767,               1'b0};
        vectors[4] = '{"small-neg",     pack6(-100, 50, -7, 3, 0, 20),          RELU ? 0 : -34,      1'b0};
        vectors[5] = '{"pos-overflow",  pack6(20000, 20000, -5000, 0, 0, 0),    32767,               1'b1};
        vectors[6] = '{"neg-overflow",  pack6(-20000, -20000, 5000, 0, 0, 0),   RELU ? 0 : -32768,   RELU ? 1'b0 : 1'b1};

        rst      = 1'b1;
        en       = 1'b1;
        inValid  = 1'b0;
        dataIn   = '0;
        inValid5 = 1'b0;
        dataIn5  = '0;
        tick();
        tick();
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset dataout", dataOut, 0);
        checkOutput("reset sat_flag", satFlag, 0);
        checkOutput("reset out_valid5", outValid5, 0);
        checkOutput("reset dataout5", dataOut5, 0);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            runVector(vectors[t].name, vectors[t].data, vectors[t].expVal, vectors[t].expSat);
        end

        $display("[TB] stream of 8 back-to-back vectors");
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 8) applyStimulus(1'b1, packAll6(cyc));
            else         applyStimulus(1'b0, '0);
            tick();
            if (cyc >= LAT - 1 && cyc <= LAT - 1 + 7) begin
                checkOutput("stream out_valid", outValid, 1);
                checkOutput("stream dataout", dataOut, 6 * (cyc - (LAT - 1)));
            end else begin
                checkOutput("stream idle out_valid", outValid, 0);
            end
        end

        $display("[TB] stall with output valid and a second vector in flight");
        applyStimulus(1'b1, packAll6(10));
        tick();
        applyStimulus(1'b1, packAll6(-3));
        tick();
        applyStimulus(1'b0, '0);
        tick();
        tick();
        checkOutput("stall first out_valid", outValid, 1);
        checkOutput("stall first dataout", dataOut, 60);
        en = 1'b0;
        applyStimulus(1'b1, packAll6(1000));
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput("stall held out_valid", outValid, 1);
            checkOutput("stall held dataout", dataOut, 60);
        end
        en = 1'b1;
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("stall second out_valid", outValid, 1);
        checkOutput("stall second dataout", dataOut, -18);
        for (int s = 0; s < 4; s++) begin
            tick();
            checkOutput("stall after out_valid", outValid, 0);
        end

        $display("[TB] data flows without valid, then reset mid-flight");
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b0, packAll6(50));
            tick();
        end
        checkOutput("invalid flow out_valid", outValid, 0);
        checkOutput("invalid flow dataout", dataOut, 300);
        applyStimulus(1'b1, packAll6(100));
        tick();
        applyStimulus(1'b1, packAll6(200));
        tick();
        applyStimulus(1'b1, packAll6(5));
        rst = 1'b1;
        en  = 1'b0;
        tick();
        checkOutput("midreset out_valid", outValid, 0);
        checkOutput("midreset dataout", dataOut, 0);
        checkOutput("midreset sat_flag", satFlag, 0);
        rst = 1'b0;
        en  = 1'b1;
        applyStimulus(1'b0, '0);
        for (int s = 0; s < 6; s++) begin
            tick();
            checkOutput("postreset no out_valid", outValid, 0);
        end
        runVector("post-reset", packAll6(7), 42, 1'b0);

        $display("[TB] five-input tree");
        runVector5("n5 minus-ones", pack5(-1, -1, -1, -1, -1), RELU ? 0 : -5, 1'b0);
        runVector5("n5 powers", pack5(1, 2, 4, 8, 16), 31, 1'b0);
        runVector5("n5 all-max", pack5(127, 127, 127, 127, 127), 127, 1'b1);
        runVector5("n5 all-min", pack5(-128, -128, -128, -128, -128), RELU ? 0 : -128, RELU ? 1'b0 : 1'b1);

        $display("[TB] randomized traffic with stalls and resets");
        advCount = 0;
        pending.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic           rCur;
            logic           eCur;
            logic           vCur;
            logic [N*W-1:0] d;
            rCur = ($urandom_range(0, 39) == 0);
            eCur = ($urandom_range(0, 3) != 0);
            vCur = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) d[i*W +: W] = 16'(randOperand());
            prevValid = outValid;
            prevData  = dataOut;
            prevSat   = satFlag;
            rst = rCur;
            en  = eCur;
            applyStimulus(vCur, d);
            tick();
            if (rCur) begin
                pending.delete();
                checkOutput("rand reset out_valid", outValid, 0);
                checkOutput("rand reset dataout", dataOut, 0);
            end else if (eCur) begin
                advCount++;
                if (vCur) begin
                    refModel(sumOperands(d), W, mVal, mSat);
                    pending.push_back('{mVal, mSat, advCount + LAT - 1});
                end
                expValid = (pending.size() > 0) && (pending[0].due == advCount);
                checkOutput("rand out_valid", outValid, expValid);
                if (expValid) begin
                    checkOutput("rand dataout", dataOut, pending[0].val);
                    checkOutput("rand sat_flag", satFlag, pending[0].sat);
                    void'(pending.pop_front());
                end
            end else begin
                checkOutput("rand stall out_valid", outValid, prevValid);
                checkOutput("rand stall dataout", dataOut, prevData);
                checkOutput("rand stall sat_flag", satFlag, prevSat);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        applyStimulus(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
